calc_sequencer: RTL and testbench

- Sequencing and accumulator stage that sits directly upstream and downstream of the combinational 16-bit arithmetic units (div and its siblings add/sub/mul).
- Registers a user operand and opcode, then drives stable operands, op select and sign mode into the arithmetic units.
- Waits a fixed settle time, then captures the selected unit's result/error into an accumulator.
- The accumulator feeds back as operand A of the next operation, giving chained calculator behaviour.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/settle_timer.sv | 28 ++
 rtl/calc_sequencer.sv | 110 +++++++++++
 tb/tb_calc_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer and the arithmetic unit result mux.
// Holds the datapath width, the opcode map and the sequencer state encoding.
package calc_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int OP_WIDTH   = 3;

    localparam logic [OP_WIDTH-1:0] OP_NOP  = 3'd0;
    localparam logic [OP_WIDTH-1:0] OP_LOAD = 3'd1;
    localparam logic [OP_WIDTH-1:0] OP_ADD  = 3'd2;
    localparam logic [OP_WIDTH-1:0] OP_SUB  = 3'd3;
    localparam logic [OP_WIDTH-1:0] OP_MUL  = 3'd4;
    localparam logic [OP_WIDTH-1:0] OP_DIV  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Opcodes that need the external units and therefore a settle period
    function automatic logic is_arith(input logic [OP_WIDTH-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counter that is loaded with a settle count and flags expiry at zero.
// Intended for reuse by any wrapper that waits on a multi-cycle unit.
module settle_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          abort,
    input  logic [CW-1:0] load_val,
    output logic          expired
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Chained-calculator sequencer: registers operands for the arithmetic units,
// waits for them to settle, then captures the selected result into the accumulator.
import calc_pkg::*;

module calc_sequencer #(
    parameter int WIDTH  = DATA_WIDTH,
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic [WIDTH-1:0]    operand,
    input  logic                signed_mode,
    input  logic                clear,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [OP_WIDTH-1:0] alu_op,
    output logic                alu_sign,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic                alu_error,
    output logic [WIDTH-1:0]    acc,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int SETTLE_W = 4;

    state_t state;
    logic   launch;
    logic   timer_expired;

    assign launch = (state == ST_IDLE) && start && !clear && is_arith(opcode);

    settle_timer #(.CW(SETTLE_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (launch),
        .abort    (clear),
        .load_val (SETTLE_W'(SETTLE - 1)),
        .expired  (timer_expired)
    );

    // clear outranks start everywhere; unit inputs are only rewritten on launch
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            acc      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= OP_NOP;
            alu_sign <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        acc <= '0;
                        err <= 1'b0;
                    end else if (start) begin
                        if (is_arith(opcode)) begin
                            alu_a    <= acc;
                            alu_b    <= operand;
                            alu_op   <= opcode;
                            alu_sign <= signed_mode;
                            busy     <= 1'b1;
                            state    <= ST_EXEC;
                        end else begin
                            if (opcode == OP_LOAD) begin
                                acc <= operand;
                            end
                            done <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (clear) begin
                        acc   <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (timer_expired) begin
                        busy <= 1'b0;
                        if (alu_error) begin
                            err   <= 1'b1;
                            state <= ST_ERR;
                        end else begin
                            acc   <= alu_result;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_ERR: begin
                    if (clear) begin
                        acc   <= '0;
                        err   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: models the external arithmetic units
// and predicts accumulator/flag behaviour operation by operation.
import calc_pkg::*;

module tb_calc_sequencer;

    localparam int W      = 16;
    localparam int SETTLE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    opcode;
    logic [W-1:0]  operand;
    logic          signed_mode;
    logic          clear;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_op;
    logic          alu_sign;
    logic [W-1:0]  alu_result;
    logic          alu_error;
    logic [W-1:0]  acc;
    logic          busy;
    logic          done;
    logic          err;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  model_acc = '0;
    bit            model_err = 1'b0;

    always #5 clk = ~clk;

    // Behaviour of the add/sub/mul/div units and their result mux
    function automatic logic [W-1:0] unit_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [2:0] op, input logic s);
        logic [31:0]          p;
        logic signed [W-1:0]  sa;
        logic signed [W-1:0]  sb;
        logic signed [W-1:0]  q;
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_MUL: begin
                p = a * b;
                return p[W-1:0];
            end
            OP_DIV: begin
                if (b == '0) return '0;
                if (s) begin
                    sa = a;
                    sb = b;
                    q  = sa / sb;
                    return q;
                end
                return a / b;
            end
            default: return '0;
        endcase
    endfunction

    assign alu_result = unit_calc(alu_a, alu_b, alu_op, alu_sign);
    assign alu_error  = (alu_op == OP_DIV) && (alu_b == '0);

    calc_sequencer #(.WIDTH(W), .SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .opcode      (opcode),
        .operand     (operand),
        .signed_mode (signed_mode),
        .clear       (clear),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_sign    (alu_sign),
        .alu_result  (alu_result),
        .alu_error   (alu_error),
        .acc         (acc),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issues one request and follows it to completion, checking every cycle
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] val,
                                 input logic sgn, input bit hold);
        logic [W-1:0] expv;
        bit           arith;
        arith = (op >= OP_ADD) && (op <= OP_DIV);
        @(negedge clk);
        start       = 1'b1;
        opcode      = op;
        operand     = val;
        signed_mode = sgn;
        @(negedge clk);
        if (!(hold && arith && !model_err)) start = 1'b0;
        if (model_err) begin
            checkOutput("err_ignore_done", done, 0);
            checkOutput("err_ignore_busy", busy, 0);
            checkOutput("err_ignore_acc", acc, model_acc);
            checkOutput("err_sticky", err, 1);
        end else if (!arith) begin
            if (op == OP_LOAD) model_acc = val;
            checkOutput("imm_done", done, 1);
            checkOutput("imm_busy", busy, 0);
            checkOutput("imm_acc", acc, model_acc);
        end else begin
            for (int i = 0; i < SETTLE; i++) begin
                checkOutput("exec_busy", busy, 1);
                checkOutput("exec_done", done, 0);
                checkOutput("exec_alu_a", alu_a, model_acc);
                checkOutput("exec_alu_b", alu_b, val);
                checkOutput("exec_alu_op", alu_op, op);
                checkOutput("exec_alu_sign", alu_sign, sgn);
                if (hold) begin
                    opcode  = 3'($urandom_range(0, 7));
                    operand = W'($urandom);
                end
                @(negedge clk);
            end
            start = 1'b0;
            checkOutput("cap_busy", busy, 0);
            if (op == OP_DIV && val == '0) begin
                model_err = 1'b1;
                checkOutput("cap_err_flag", err, 1);
                checkOutput("cap_err_done", done, 0);
                checkOutput("cap_err_acc", acc, model_acc);
            end else begin
                expv = unit_calc(model_acc, val, op, sgn);
                model_acc = expv;
                checkOutput("cap_done", done, 1);
                checkOutput("cap_acc", acc, expv);
                checkOutput("cap_err_clear", err, 0);
            end
        end
        @(negedge clk);
        checkOutput("done_single", done, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_err", err, model_err);
        checkOutput("idle_acc", acc, model_acc);
    endtask

    task automatic doClear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_acc = '0;
        model_err = 1'b0;
        checkOutput("clr_acc", acc, 0);
        checkOutput("clr_err", err, 0);
        checkOutput("clr_done", done, 0);
        checkOutput("clr_busy", busy, 0);
    endtask

    initial begin
        logic [2:0]   rop;
        logic [W-1:0] rval;
        rst = 1'b1; start = 1'b0; opcode = '0; operand = '0; signed_mode = 1'b0; clear = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_acc", acc, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_alu_b", alu_b, 0);
        checkOutput("rst_alu_op", alu_op, 0);
        checkOutput("rst_alu_sign", alu_sign, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        rst = 1'b0;

        applyStimulus(OP_LOAD, 16'd100, 1'b0, 1'b0);
        applyStimulus(OP_DIV, 16'd2, 1'b0, 1'b0);
        checkOutput("div_100_2", acc, 16'h0032);

        applyStimulus(OP_LOAD, 16'd8, 1'b0, 1'b0);
        applyStimulus(OP_DIV, 16'd4, 1'b0, 1'b0);
        checkOutput("chain_div", acc, 16'd2);
        applyStimulus(OP_ADD, 16'd5, 1'b0, 1'b0);
        checkOutput("chain_add", acc, 16'd7);

        applyStimulus(OP_LOAD, 16'hFFF8, 1'b0, 1'b0);
        applyStimulus(OP_DIV, 16'd4, 1'b1, 1'b0);
        checkOutput("sdiv_neg8_4", acc, 16'hFFFE);

        applyStimulus(OP_LOAD, 16'd10, 1'b0, 1'b0);
        applyStimulus(OP_DIV, 16'd0, 1'b0, 1'b0);
        checkOutput("div0_acc", acc, 16'd10);
        applyStimulus(OP_LOAD, 16'd33, 1'b0, 1'b0);
        doClear();

        applyStimulus(OP_LOAD, 16'd3, 1'b0, 1'b0);
        applyStimulus(OP_MUL, 16'd7, 1'b0, 1'b1);
        checkOutput("hold_mul", acc, 16'd21);
        applyStimulus(3'd7, 16'h1234, 1'b0, 1'b0);
        checkOutput("reserved_acc", acc, 16'd21);

        // Reset arriving before the capture edge
        @(negedge clk);
        start = 1'b1; opcode = OP_ADD; operand = 16'd9;
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_acc = '0;
        checkOutput("midrst_acc", acc, 0);
        checkOutput("midrst_alu_a", alu_a, 0);
        checkOutput("midrst_alu_b", alu_b, 0);
        checkOutput("midrst_alu_op", alu_op, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        @(negedge clk);
        checkOutput("midrst_nodone", done, 0);

        // Clear arriving during EXEC
        applyStimulus(OP_LOAD, 16'd50, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; opcode = OP_SUB; operand = 16'd1;
        @(negedge clk);
        start = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_acc = '0;
        checkOutput("exclr_acc", acc, 0);
        checkOutput("exclr_busy", busy, 0);
        checkOutput("exclr_done", done, 0);
        repeat (SETTLE) begin
            @(negedge clk);
            checkOutput("exclr_nocap_done", done, 0);
            checkOutput("exclr_nocap_acc", acc, 0);
        end

        for (int n = 0; n < 80; n++) begin
            if (model_err && $urandom_range(0, 1) == 0) doClear();
            rop  = 3'($urandom_range(0, 7));
            rval = W'($urandom);
            if ($urandom_range(0, 7) == 0) rval = '0;
            applyStimulus(rop, rval, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
